// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// Frame format: one start bit (0), eight data bits sent LSB first, one stop bit (1).
// The idle line is high.
// The serial input passes through a two-flop synchroniser before the FSM sees it.
// The start bit and every data/stop bit are sampled at mid-bit.
// A good byte updates rx_data and pulses rx_valid for one cycle.
// A stop bit sampled low pulses frame_err for one cycle and leaves rx_data unchanged.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  // The mid-bit sampling scheme needs a few cycles per bit to leave any margin.
  if (CLKS_PER_BIT < 4) begin : g_bad_cfg
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] clk_count_q, clk_count_d;
  logic [2:0]       bit_index_q, bit_index_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       rx_data_q,   rx_data_d;
  logic             rx_valid_q,  rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_busy_q,   rx_busy_d;
  logic [1:0]       sync_q,      sync_d;
  logic             rx_s;

  assign sync_d = {sync_q[0], rx};
  assign rx_s   = sync_q[1];

  // Next-state logic: every register holds its value unless this block changes it.
  // The two strobes default to 0 each cycle.
  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_busy_d   = rx_busy_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_count_d = '0;
        bit_index_d = 3'd0;
        rx_busy_d   = 1'b0;
        if (!rx_s) begin
          state_d   = START;
          rx_busy_d = 1'b1;
        end
      end

      START: begin
        if (clk_count_q < HALF_CNT) begin
          clk_count_d = clk_count_q + 1'b1;
        end else begin
          clk_count_d = '0;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            // The line went high again before mid-start: a glitch, not a start bit.
            state_d   = IDLE;
            rx_busy_d = 1'b0;
          end
        end
      end

      DATA: begin
        if (clk_count_q < LAST_CNT) begin
          clk_count_d = clk_count_q + 1'b1;
        end else begin
          clk_count_d          = '0;
          shift_d[bit_index_q] = rx_s;
          if (bit_index_q < 3'd7) begin
            bit_index_d = bit_index_q + 3'd1;
          end else begin
            bit_index_d = 3'd0;
            state_d     = STOP;
          end
        end
      end

      STOP: begin
        if (clk_count_q < LAST_CNT) begin
          clk_count_d = clk_count_q + 1'b1;
        end else begin
          clk_count_d = '0;
          state_d     = CLEANUP;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      CLEANUP: begin
        // Wait for the line to go high so that a held-low (break) line cannot
        // retrigger a start.
        if (rx_s) begin
          state_d   = IDLE;
          rx_busy_d = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        rx_busy_d = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  // Reset leaves the synchroniser reading an idle (high) line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_index_q <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bench for uart_rx at CLKS_PER_BIT=10.
// The bench itself drives 8N1 frames onto rx, taking the place of the paired transmitter.
// Each frame it sends pushes the strobe it expects into a queue.
// A negedge monitor pops that entry and compares it whenever rx_valid or frame_err fires.
module tb_uart_rx;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         gap;
    logic       exp_valid;
    logic       exp_err;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[8];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int b = 0; b < 8; b++) begin
      rx = data[b];
      tick(CPB / 2);
      if (b == 0) chk("busy_mid_frame", 32'(rx_busy), 32'd1);
      tick(CPB - CPB / 2);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  task automatic push_valid(input logic [7:0] data);
    sb_q.push_back({1'b0, data});
    last_good = data;
  endtask

  task automatic push_err();
    sb_q.push_back({1'b1, last_good});
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && (rx_valid || frame_err)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", 32'({frame_err, rx_valid}), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("strobe_kind", 32'({frame_err, rx_valid}), e.is_err ? 32'd2 : 32'd1);
        chk("rx_data", 32'(rx_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 0, 1'b1, 1'b0};
    vecs[3] = '{8'h55, 1'b1, 0, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 1'b0, 4, 1'b0, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 3, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 0, 1'b1, 1'b0};
    vecs[7] = '{8'h7E, 1'b1, 2, 1'b1, 1'b0};

    rx    = 1'b1;
    rst_n = 1'b0;
    tick(3);
    chk("reset_rx_data",   32'(rx_data),   32'h00);
    chk("reset_rx_valid",  32'(rx_valid),  32'd0);
    chk("reset_rx_busy",   32'(rx_busy),   32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_busy", 32'(rx_busy), 32'd0);

    // Table-driven frames: single byte, back-to-back run, framing error, more bytes.
    for (int i = 0; i < 8; i++) begin
      rx = 1'b1;
      tick(vecs[i].gap);
      if (vecs[i].exp_valid) push_valid(vecs[i].data);
      if (vecs[i].exp_err)   push_err();
      send_frame(vecs[i].data, vecs[i].stop_bit);
      chk("strobe_pending", 32'(sb_q.size()), 32'd0);
    end
    rx = 1'b1;
    tick(4);
    chk("busy_after_table", 32'(rx_busy), 32'd0);

    // Glitch: three low cycles is shorter than half a bit, so no frame starts.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(12);
    chk("glitch_busy", 32'(rx_busy), 32'd0);
    chk("glitch_rx_data", 32'(rx_data), 32'(last_good));
    push_valid(8'h3C);
    send_frame(8'h3C, 1'b1);
    chk("after_glitch_pending", 32'(sb_q.size()), 32'd0);
    rx = 1'b1;
    tick(4);

    // Framing error followed by a held-low line: the receiver must not restart.
    push_err();
    send_frame(8'h81, 1'b0);
    tick(30);
    chk("break_busy_held", 32'(rx_busy), 32'd1);
    chk("break_pending", 32'(sb_q.size()), 32'd0);
    chk("break_rx_data_hold", 32'(rx_data), 32'(last_good));
    rx = 1'b1;
    tick(5);
    chk("break_release_busy", 32'(rx_busy), 32'd0);

    // Reset asserted part-way through the data bits of 8'hC3.
    rx = 1'b0;
    tick(CPB);
    for (int b = 0; b < 3; b++) begin
      rx = (b < 2) ? 1'b1 : 1'b0;
      tick(CPB);
    end
    chk("pre_reset_busy", 32'(rx_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rx_data",   32'(rx_data),   32'h00);
    chk("async_reset_rx_busy",   32'(rx_busy),   32'd0);
    chk("async_reset_rx_valid",  32'(rx_valid),  32'd0);
    chk("async_reset_frame_err", 32'(frame_err), 32'd0);
    last_good = 8'h00;
    rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    push_valid(8'h12);
    send_frame(8'h12, 1'b1);
    rx = 1'b1;
    tick(5);
    chk("final_pending", 32'(sb_q.size()), 32'd0);
    chk("final_busy", 32'(rx_busy), 32'd0);
    chk("final_rx_data", 32'(rx_data), 32'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
